// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side consumer of the dual-clock FIFO.
// Pops FIFO words into a 2-entry prefetch/skid buffer and presents them as a
// valid/ready stream with m_last framing every FRAME_LEN beats.
// Optional build macro FIFO_READER_STATS_EN adds stat_words / stat_stall.
module fifo_stream_reader #(
    parameter int unsigned DSIZE     = 8,
    parameter int unsigned FRAME_LEN = 16
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             en,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DSIZE-1:0] m_data,
    output logic             m_last,
    output logic             frame_busy
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [31:0]      stat_words,
    output logic [31:0]      stat_stall
`endif
);

    localparam int unsigned CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_LEN - 1);

    logic [DSIZE-1:0] buf0_q, buf0_d;
    logic [DSIZE-1:0] buf1_q, buf1_d;
    logic [1:0]       occ_q, occ_d;
    logic [CW-1:0]    beat_q, beat_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             pop_c;
    logic             rinc_c;

    // Pop decision, buffer shuffling and frame counting for this cycle.
    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        occ_d  = occ_q;
        beat_d = beat_q;

        pop_c  = valid_q && m_ready;
        // A full buffer may still accept a word when its head leaves this cycle.
        rinc_c = !rrst && en && !rempty && ((occ_q != 2'd2) || pop_c);

        case ({rinc_c, pop_c})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    buf0_d = rdata;
                end else begin
                    buf1_d = rdata;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Head leaves; new word lands behind whatever remains.
                if (occ_q == 2'd1) begin
                    buf0_d = rdata;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = rdata;
                end
            end
            default: begin
            end
        endcase

        if (pop_c) begin
            beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + CW'(1);
        end

        valid_d = (occ_d != 2'd0);
        last_d  = valid_d && (beat_d == LAST_BEAT);
        busy_d  = (beat_d != '0);
    end

    // Control state with synchronous reset.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            occ_q   <= 2'd0;
            beat_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            occ_q   <= occ_d;
            beat_q  <= beat_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    // Data storage needs no reset; occupancy qualifies it.
    always_ff @(posedge rclk) begin
        buf0_q <= buf0_d;
        buf1_q <= buf1_d;
    end

    assign rinc       = rinc_c;
    assign m_valid    = valid_q;
    assign m_data     = buf0_q;
    assign m_last     = last_q;
    assign frame_busy = busy_q;

`ifdef FIFO_READER_STATS_EN
    logic [31:0] words_q, words_d;
    logic [31:0] stall_q, stall_d;

    // Saturating counters of pops and starved cycles.
    always_comb begin
        words_d = words_q;
        stall_d = stall_q;
        if (rinc_c && (words_q != '1)) begin
            words_d = words_q + 32'd1;
        end
        if (!valid_q && en && rempty && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Statistics registers, cleared by reset.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            words_q <= '0;
            stall_q <= '0;
        end else begin
            words_q <= words_d;
            stall_q <= stall_d;
        end
    end

    assign stat_words = words_q;
    assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural FIFO model and
// a scoreboard of words popped from it; a second FRAME_LEN=1 instance
// shares the inputs to cover the single-beat frame corner.
module tb_fifo_stream_reader;

    logic       rclk = 1'b0;
    logic       rrst;
    logic       en;
    logic       rempty;
    logic [7:0] rdata;
    logic       m_ready;

    logic       rinc, m_valid, m_last, frame_busy;
    logic [7:0] m_data;
    logic       u1_rinc, u1_m_valid, u1_m_last, u1_frame_busy;
    logic [7:0] u1_m_data;
`ifdef FIFO_READER_STATS_EN
    logic [31:0] stat_words, stat_stall, u1_stat_words, u1_stat_stall;
`endif

    always #5 rclk = ~rclk;

    fifo_stream_reader #(.DSIZE(8), .FRAME_LEN(4)) dut (
        .rclk(rclk), .rrst(rrst), .en(en), .rempty(rempty), .rdata(rdata),
        .rinc(rinc), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .frame_busy(frame_busy)
`ifdef FIFO_READER_STATS_EN
        , .stat_words(stat_words), .stat_stall(stat_stall)
`endif
    );

    fifo_stream_reader #(.DSIZE(8), .FRAME_LEN(1)) u1 (
        .rclk(rclk), .rrst(rrst), .en(en), .rempty(rempty), .rdata(rdata),
        .rinc(u1_rinc), .m_valid(u1_m_valid), .m_ready(m_ready), .m_data(u1_m_data),
        .m_last(u1_m_last), .frame_busy(u1_frame_busy)
`ifdef FIFO_READER_STATS_EN
        , .stat_words(u1_stat_words), .stat_stall(u1_stat_stall)
`endif
    );

    logic [7:0] fifo_q[$];
    logic [7:0] inflight[$];
    logic [7:0] hs_data[$];
    int         hs_cyc[$];
    bit         hs_last[$];
    int         cyc;
    int         exp_beat;
    int         rinc_cnt;
    int         checks;
    int         failures;
    bit         hide;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_fifo_pins();
        rempty = (fifo_q.size() == 0) || hide;
        rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic load_seq(input int base, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(8'(base + i));
        set_fifo_pins();
    endtask

    task automatic clear_log();
        hs_data.delete();
        hs_cyc.delete();
        hs_last.delete();
    endtask

    // One clock cycle: check at the falling edge, apply FIFO pops after the rising edge.
    task automatic step();
        logic rinc_s;
        logic rst_s;
        @(negedge rclk);
        chk("no_underflow", 32'(rinc & rempty), 32'd0);
        chk("valid_vs_occ", 32'(m_valid), 32'(inflight.size() != 0));
        chk("busy", 32'(frame_busy), 32'(exp_beat != 0));
        chk("last", 32'(m_last), 32'(m_valid && (exp_beat == 3)));
        chk("fl1_valid", 32'(u1_m_valid), 32'(m_valid));
        chk("fl1_last", 32'(u1_m_last), 32'(u1_m_valid));
        chk("fl1_busy", 32'(u1_frame_busy), 32'd0);
        if (rrst) chk("rst_rinc", 32'(rinc), 32'd0);
        if (m_valid && m_ready && (inflight.size() != 0)) begin
            chk("data", 32'(m_data), 32'(inflight[0]));
            hs_data.push_back(m_data);
            hs_cyc.push_back(cyc);
            hs_last.push_back(m_last);
            void'(inflight.pop_front());
            exp_beat = (exp_beat == 3) ? 0 : exp_beat + 1;
        end
        rinc_s = rinc;
        rst_s  = rrst;
        if (rinc_s) begin
            inflight.push_back(rdata);
            rinc_cnt++;
        end
        cyc++;
        @(posedge rclk);
        #1;
        if (rinc_s && (fifo_q.size() != 0)) void'(fifo_q.pop_front());
        if (rst_s) begin
            inflight.delete();
            exp_beat = 0;
        end
        set_fifo_pins();
    endtask

    initial begin
        int c0;
        int k;
        checks = 0; failures = 0; cyc = 0; exp_beat = 0; rinc_cnt = 0; hide = 0;
        rrst = 1'b1; en = 1'b1; m_ready = 1'b1;
        set_fifo_pins();

        // Reset, then preload while reset is still held.
        step();
        step();
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_last", 32'(m_last), 32'd0);
        chk("rst_busy", 32'(frame_busy), 32'd0);
        load_seq(8'h11, 4);
        #1;
        chk("rst_gates_rinc", 32'(rinc), 32'd0);
        step();

        // Basic latency and back-to-back streaming.
        rrst = 1'b0;
        c0 = cyc;
        rinc_cnt = 0;
        clear_log();
        for (int i = 0; i < 8; i++) step();
        chk("t1_beats", 32'(hs_data.size()), 32'd4);
        for (int i = 0; i < 4 && i < hs_data.size(); i++) begin
            chk("t1_data", 32'(hs_data[i]), 32'(8'h11 + i));
            chk("t1_cycle", 32'(hs_cyc[i]), 32'(c0 + 1 + i));
        end
        chk("t1_rinc_cnt", 32'(rinc_cnt), 32'd4);
`ifdef FIFO_READER_STATS_EN
        chk("t1_stat_words", stat_words, 32'd4);
        chk("t1_stat_stall", stat_stall, 32'd3);
`endif

        // Frame delimiting over 12 beats.
        clear_log();
        load_seq(8'h20, 12);
        for (int i = 0; i < 16; i++) step();
        chk("t2_beats", 32'(hs_data.size()), 32'd12);
        for (int i = 0; i < 12 && i < hs_last.size(); i++)
            chk("t2_last", 32'(hs_last[i]), 32'((i % 4) == 3));
        chk("t2_busy_end", 32'(frame_busy), 32'd0);

        // Downstream stall with a full FIFO, then release.
        clear_log();
        m_ready = 1'b0;
        rinc_cnt = 0;
        load_seq(8'h30, 10);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t3_hold_valid", 32'(m_valid), 32'd1);
            chk("t3_hold_data", 32'(m_data), 32'h30);
        end
        chk("t3_stall_rinc", 32'(rinc_cnt), 32'd2);
        m_ready = 1'b1;
        for (int i = 0; i < 14; i++) step();
        chk("t3_beats", 32'(hs_data.size()), 32'd10);
        for (int i = 0; i < 10 && i < hs_data.size(); i++)
            chk("t3_order", 32'(hs_data[i]), 32'(8'h30 + i));

        // Toggling m_ready with a randomly starved FIFO, 1000 words.
        clear_log();
        for (int i = 0; i < 1000; i++) fifo_q.push_back(8'($urandom));
        k = 0;
        while ((hs_data.size() < 1000) && (k < 8000)) begin
            hide = ($urandom_range(0, 3) == 0);
            set_fifo_pins();
            m_ready = cyc[0];
            step();
            k++;
        end
        chk("t4_beats", 32'(hs_data.size()), 32'd1000);
        hide = 0;
        m_ready = 1'b1;
        set_fifo_pins();
        for (int i = 0; i < 4; i++) step();

        // en low with a full buffer: drain without popping.
        clear_log();
        m_ready = 1'b0;
        rinc_cnt = 0;
        load_seq(8'h50, 4);
        for (int i = 0; i < 3; i++) step();
        chk("t5_fill_rinc", 32'(rinc_cnt), 32'd2);
        en = 1'b0;
        m_ready = 1'b1;
        rinc_cnt = 0;
        for (int i = 0; i < 5; i++) step();
        chk("t5_no_rinc", 32'(rinc_cnt), 32'd0);
        chk("t5_drained", 32'(hs_data.size()), 32'd2);
        chk("t5_empty", 32'(m_valid), 32'd0);
        en = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("t5_resume_rinc", 32'(rinc_cnt), 32'd2);
        chk("t5_total", 32'(hs_data.size()), 32'd4);
        if (hs_data.size() == 4) chk("t5_tail", 32'(hs_data[3]), 32'h53);

        // Reset after beat 2 of a frame.
        rrst = 1'b1;
        step();
        rrst = 1'b0;
        clear_log();
        load_seq(8'h60, 8);
        k = 0;
        while ((hs_data.size() < 2) && (k < 20)) begin
            step();
            k++;
        end
        chk("t6_two_beats", 32'(hs_data.size()), 32'd2);
        rrst = 1'b1;
        m_ready = 1'b0;
        step();
        rrst = 1'b0;
        m_ready = 1'b1;
        chk("t6_valid_after_rst", 32'(m_valid), 32'd0);
        chk("t6_busy_after_rst", 32'(frame_busy), 32'd0);
`ifdef FIFO_READER_STATS_EN
        chk("t6_stat_words", stat_words, 32'd0);
        chk("t6_stat_stall", stat_stall, 32'd0);
`endif
        clear_log();
        for (int i = 0; i < 8; i++) step();
        chk("t6_beats", 32'(hs_data.size()), 32'd5);
        if (hs_data.size() == 5) begin
            chk("t6_first", 32'(hs_data[0]), 32'h63);
            chk("t6_last0", 32'(hs_last[0]), 32'd0);
            chk("t6_last1", 32'(hs_last[1]), 32'd0);
            chk("t6_last2", 32'(hs_last[2]), 32'd0);
            chk("t6_last3", 32'(hs_last[3]), 32'd1);
            chk("t6_last4", 32'(hs_last[4]), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
